motor_enable_ctrl: RTL

Consumer of the overcurrent detector's `oc_flag`. It drives the H-bridge enable lines ENA/ENB as PWM from commanded duty cycles. On a trip it removes drive within one clock and holds the bridge off for a cooldown period. It retries a bounded number of times, then latches a lockout that only an explicit clear can release. It sits between the rover's motion controller (run/duty commands) and the motor driver pins.

---
 rtl/motor_enable_ctrl.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/motor_enable_ctrl.sv
// H-bridge enable controller: PWM drive from duty commands, trip-off on oc_flag,
// cooldown/retry with latched lockout. Define SOFT_START_EN to add the RAMP soft-start state.
module motor_enable_ctrl #(
   parameter int unsigned PWM_PERIOD       = 1000,
   parameter int unsigned DUTY_W           = 10,
   parameter int unsigned COOLDOWN_CYCLES  = 50_000_000,
   parameter int unsigned MAX_RETRIES      = 3,
   parameter int unsigned RAMP_STEP_CYCLES = 10_000
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               oc_flag,
   input  logic                               run_a,
   input  logic                               run_b,
   input  logic [DUTY_W-1:0]                  duty_a,
   input  logic [DUTY_W-1:0]                  duty_b,
   input  logic                               clear_fault,
   output logic                               ENA,
   output logic                               ENB,
   output logic                               fault,
   output logic                               locked_out,
   output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

   localparam int unsigned PWM_W   = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
   localparam int unsigned CNT_W   = (COOLDOWN_CYCLES > 1) ? $clog2(COOLDOWN_CYCLES) : 1;
   localparam int unsigned RETRY_W = $clog2(MAX_RETRIES+1);

   localparam logic [PWM_W-1:0]   PWM_LAST  = PWM_W'(PWM_PERIOD - 1);
   localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(COOLDOWN_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RAMP,
      S_RUN,
      S_FAULT_COOL,
      S_LOCKOUT
   } state_e;

   state_e               state_q, state_d;
   logic [PWM_W-1:0]     pwm_q, pwm_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
   logic                 ena_q, ena_d, enb_q, enb_d;
   logic                 fault_q, fault_d, lock_q, lock_d;
   logic                 trip, drive;
   logic [31:0]          lim, eff_a, eff_b;

`ifdef SOFT_START_EN
   localparam int unsigned RAMP_W = $clog2(PWM_PERIOD + 1);
   localparam int unsigned STEP_W = (RAMP_STEP_CYCLES > 1) ? $clog2(RAMP_STEP_CYCLES) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(RAMP_STEP_CYCLES - 1);

   logic [RAMP_W-1:0] ramp_q, ramp_d;
   logic [STEP_W-1:0] step_q, step_d;
   localparam state_e S_ENTRY = S_RAMP;
`else
   localparam state_e S_ENTRY = S_RUN;

   // Ramp step length has no effect without soft-start.
   if (RAMP_STEP_CYCLES == 0) begin : g_no_ramp_step
   end
`endif

   // Free-running PWM frame counter.
   always_comb begin : pwm_comb
      pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + PWM_W'(1);
   end

   always_comb begin : fsm_comb
      state_d   = state_q;
      cnt_d     = cnt_q;
      retry_d   = retry_q;
      trip      = 1'b0;
      retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RETRY_W'(1);
`ifdef SOFT_START_EN
      ramp_d    = ramp_q;
      step_d    = step_q;
`endif

      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
`ifdef SOFT_START_EN
            ramp_d = '0;
            step_d = '0;
`endif
            if ((run_a || run_b) && !oc_flag) begin
               state_d = S_ENTRY;
            end
         end
`ifdef SOFT_START_EN
         S_RAMP: begin
            if (oc_flag) begin
               trip = 1'b1;
            end else if (!(run_a || run_b)) begin
               state_d = S_IDLE;
            end else begin
               if (step_q == STEP_LAST) begin
                  step_d = '0;
                  ramp_d = ramp_q + RAMP_W'(1);
               end else begin
                  step_d = step_q + STEP_W'(1);
               end
               if (32'(ramp_d) >= PWM_PERIOD) begin
                  state_d = S_RUN;
                  cnt_d   = '0;
               end
            end
         end
`endif
         S_RUN: begin
            // cnt_q counts consecutive clean RUN clocks and saturates at the window end.
            if (oc_flag) begin
               trip = 1'b1;
            end else if (!(run_a || run_b)) begin
               state_d = S_IDLE;
            end else if (cnt_q == CNT_LAST) begin
               retry_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_FAULT_COOL: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d = '0;
               if (!oc_flag) begin
                  state_d = S_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_LOCKOUT: begin
            if (clear_fault && !oc_flag) begin
               state_d = S_IDLE;
               retry_d = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (trip) begin
         retry_d = retry_inc;
         cnt_d   = '0;
         state_d = (retry_inc == RETRY_MAX) ? S_LOCKOUT : S_FAULT_COOL;
      end
   end

   // Outputs are computed from the next state so a trip removes drive at the same edge.
   always_comb begin : out_comb
      drive = (state_d == S_RUN) || (state_d == S_RAMP);
      lim   = PWM_PERIOD;
`ifdef SOFT_START_EN
      if (state_d == S_RAMP) begin
         lim = 32'(ramp_d);
      end
`endif
      eff_a   = (32'(duty_a) < lim) ? 32'(duty_a) : lim;
      eff_b   = (32'(duty_b) < lim) ? 32'(duty_b) : lim;
      ena_d   = run_a && drive && (32'(pwm_d) < eff_a);
      enb_d   = run_b && drive && (32'(pwm_d) < eff_b);
      fault_d = (state_d == S_FAULT_COOL) || (state_d == S_LOCKOUT);
      lock_d  = (state_d == S_LOCKOUT);
   end

   always_ff @(posedge clk) begin : regs
      if (reset) begin
         state_q <= S_IDLE;
         pwm_q   <= '0;
         cnt_q   <= '0;
         retry_q <= '0;
         ena_q   <= 1'b0;
         enb_q   <= 1'b0;
         fault_q <= 1'b0;
         lock_q  <= 1'b0;
`ifdef SOFT_START_EN
         ramp_q  <= '0;
         step_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         pwm_q   <= pwm_d;
         cnt_q   <= cnt_d;
         retry_q <= retry_d;
         ena_q   <= ena_d;
         enb_q   <= enb_d;
         fault_q <= fault_d;
         lock_q  <= lock_d;
`ifdef SOFT_START_EN
         ramp_q  <= ramp_d;
         step_q  <= step_d;
`endif
      end
   end

   assign ENA         = ena_q;
   assign ENB         = enb_q;
   assign fault       = fault_q;
   assign locked_out  = lock_q;
   assign retry_count = retry_q;

endmodule
